axis_read_interface: RTL and testbench

- Downstream neighbour of the AXIS-to-BRAM write stage: reads a stored packet back out of the shared BRAM and emits it as an AXI-Stream master (toward PCIe completion / requester path).
- Started by a single-cycle command giving start address, beat count and final-beat byte mask.
- Absorbs the 1-cycle BRAM read latency with a 2-entry output buffer, so full back-pressure is honoured with no beat lost or duplicated.

---
 rtl/axis_read_interface.sv | 156 +++++++++++++++
 tb/tb_axis_read_interface.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/axis_read_interface.sv
// Reads a stored packet back out of BRAM and emits it as an AXI-Stream master.
// A 2-entry skid buffer absorbs the 1-cycle BRAM read latency under back-pressure.
module axis_read_interface #(
  parameter int data_width     = 512,
  parameter int counter_width  = 10,
  parameter int mem_size_depth = 1024,
  parameter int keep_width     = data_width / 8
) (
  input  logic                     axis_clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [counter_width-1:0] start_addr,
  input  logic [counter_width:0]   beat_count,
  input  logic [keep_width-1:0]    last_keep,
  output logic                     busy,
  output logic                     done,
  output logic                     bram_ena,
  output logic [counter_width-1:0] bram_address,
  input  logic [data_width-1:0]    bram_dout,
  output logic                     t_valid,
  input  logic                     t_ready,
  output logic [data_width-1:0]    t_data,
  output logic [keep_width-1:0]    t_keep,
  output logic                     t_last
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, FINISH} state_t;

  localparam logic [counter_width:0]   DepthCount = (counter_width+1)'(mem_size_depth);
  localparam logic [counter_width-1:0] LastAddr   = counter_width'(mem_size_depth - 1);

  state_t                   state_q, state_d;
  logic [counter_width-1:0] addr_q, addr_d;
  logic [counter_width:0]   remaining_q, remaining_d;
  logic [keep_width-1:0]    lastKeep_q, lastKeep_d;
  logic                     inflight_q, inflightLast_q;

  logic [data_width-1:0]    bufData_q [2];
  logic [keep_width-1:0]    bufKeep_q [2];
  logic [1:0]               bufLast_q;
  logic                     rdPtr_q, wrPtr_q;
  logic [1:0]               count_q;

  logic                     issue;
  logic                     push;
  logic                     pop;
  logic                     room;
  logic [2:0]               pending;
  logic [counter_width:0]   clampedCount;
  logic [counter_width-1:0] nextAddr;

  assign push         = inflight_q;
  assign pop          = (count_q != 2'd0) && t_ready;
  assign pending      = {1'b0, count_q} + {2'b00, inflight_q};
  // A beat leaving this cycle frees a slot for the read issued now.
  assign room         = pop ? (pending < 3'd3) : (pending < 3'd2);
  assign clampedCount = (beat_count > DepthCount) ? DepthCount : beat_count;
  assign nextAddr     = (addr_q == LastAddr) ? '0 : addr_q + 1'b1;

  assign t_valid      = (count_q != 2'd0);
  assign t_data       = bufData_q[rdPtr_q];
  assign t_keep       = bufKeep_q[rdPtr_q];
  assign t_last       = bufLast_q[rdPtr_q];
  assign bram_ena     = issue;
  assign bram_address = addr_q;

  always_ff @(posedge axis_clk) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      lastKeep_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      lastKeep_q  <= lastKeep_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    lastKeep_d  = lastKeep_q;
    issue       = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (beat_count != '0) begin
            addr_d      = start_addr;
            remaining_d = clampedCount;
            lastKeep_d  = (last_keep == '0) ? '1 : last_keep;
            state_d     = READ;
          end else begin
            state_d     = FINISH;
          end
        end
      end
      READ: begin
        busy = 1'b1;
        if (remaining_q == '0) begin
          state_d = DRAIN;
        end else if (room) begin
          issue       = 1'b1;
          addr_d      = nextAddr;
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == (counter_width+1)'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (pop && t_last) state_d = FINISH;
      end
      FINISH: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Read pipeline tag plus the 2-entry output FIFO; push and pop may coincide.
  always_ff @(posedge axis_clk) begin
    if (reset) begin
      inflight_q     <= 1'b0;
      inflightLast_q <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        bufData_q[i] <= '0;
        bufKeep_q[i] <= '0;
      end
      bufLast_q <= '0;
      rdPtr_q   <= 1'b0;
      wrPtr_q   <= 1'b0;
      count_q   <= '0;
    end else begin
      inflight_q     <= issue;
      inflightLast_q <= issue && (remaining_q == (counter_width+1)'(1));
      if (push) begin
        bufData_q[wrPtr_q] <= bram_dout;
        bufKeep_q[wrPtr_q] <= inflightLast_q ? lastKeep_q : '1;
        bufLast_q[wrPtr_q] <= inflightLast_q;
        wrPtr_q            <= ~wrPtr_q;
      end
      if (pop) rdPtr_q <= ~rdPtr_q;
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_read_interface.sv
// Directed bench for axis_read_interface with a BRAM model holding mem[a] = a.
// Monitors log reads, beats and done pulses; packets are then checked against expected streams.
module tb_axis_read_interface;

  localparam int DW = 512;
  localparam int CW = 10;
  localparam int DEPTH = 1024;
  localparam int KW = DW / 8;
  localparam logic [63:0] AllOnes = 64'hFFFF_FFFF_FFFF_FFFF;

  logic          axis_clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [CW-1:0] start_addr = '0;
  logic [CW:0]   beat_count = '0;
  logic [KW-1:0] last_keep = '0;
  logic          busy, done, bram_ena;
  logic [CW-1:0] bram_address;
  logic [DW-1:0] bram_dout = '0;
  logic          t_valid;
  logic          t_ready = 1'b1;
  logic [DW-1:0] t_data;
  logic [KW-1:0] t_keep;
  logic          t_last;

  int assertCount = 0;
  int failCount = 0;
  int cyc = 0;

  int          enaCyc[$];
  int          enaAddr[$];
  int          beatCyc[$];
  logic [63:0] beatData[$];
  logic [63:0] beatKeep[$];
  logic        beatLast[$];
  int          doneCyc[$];
  int          stallErr = 0;
  int          outErr = 0;
  int          outstanding = 0;
  bit          prevStall = 0;
  logic [63:0] prevData, prevKeep;
  logic        prevLast;

  bit readyPat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  axis_read_interface #(
    .data_width(DW), .counter_width(CW), .mem_size_depth(DEPTH), .keep_width(KW)
  ) dut (
    .axis_clk(axis_clk), .reset(reset), .start(start), .start_addr(start_addr),
    .beat_count(beat_count), .last_keep(last_keep), .busy(busy), .done(done),
    .bram_ena(bram_ena), .bram_address(bram_address), .bram_dout(bram_dout),
    .t_valid(t_valid), .t_ready(t_ready), .t_data(t_data), .t_keep(t_keep), .t_last(t_last)
  );

  initial forever #5 axis_clk = ~axis_clk;

  always @(posedge axis_clk) cyc <= cyc + 1;

  // Synchronous-read BRAM whose contents equal the address.
  always @(posedge axis_clk) if (bram_ena) bram_dout <= DW'(bram_address);

  // Mid-cycle monitor: inputs were driven on the falling edge, outputs settled since the rising edge.
  always @(negedge axis_clk) begin
    #2;
    if (bram_ena) begin
      enaCyc.push_back(cyc);
      enaAddr.push_back(int'(bram_address));
    end
    if (t_valid && t_ready) begin
      beatCyc.push_back(cyc);
      beatData.push_back(t_data[63:0]);
      beatKeep.push_back(t_keep);
      beatLast.push_back(t_last);
    end
    if (done) doneCyc.push_back(cyc);
    if (prevStall && (!t_valid || t_data[63:0] != prevData || t_keep != prevKeep || t_last != prevLast))
      stallErr++;
    if (reset) begin
      outstanding = 0;
      prevStall = 0;
    end else begin
      outstanding = outstanding + int'(bram_ena) - int'(t_valid && t_ready);
      if (outstanding > 2) outErr++;
      prevStall = t_valid && !t_ready;
      prevData = t_data[63:0];
      prevKeep = t_keep;
      prevLast = t_last;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic clearLogs();
    enaCyc.delete(); enaAddr.delete(); beatCyc.delete(); beatData.delete();
    beatKeep.delete(); beatLast.delete(); doneCyc.delete();
    stallErr = 0; outErr = 0; outstanding = 0; prevStall = 0;
  endtask

  task automatic applyStimulus(input logic [CW-1:0] addr, input logic [CW:0] count, input logic [KW-1:0] keep,
                               input bit stallMode, input bit secondStart, output int startCyc);
    bit finished;
    @(negedge axis_clk);
    clearLogs();
    start = 1'b1; start_addr = addr; beat_count = count; last_keep = keep; t_ready = 1'b1;
    startCyc = cyc;
    finished = 0;
    for (int k = 0; k < 3000 && !finished; k++) begin
      @(negedge axis_clk);
      start = secondStart && (k == 10);
      if (start) begin
        start_addr = 10'd500; beat_count = 11'd3;
      end
      t_ready = stallMode ? readyPat[(k + 1) % 4] : 1'b1;
      #3;
      if (doneCyc.size() > 0) finished = 1;
    end
    checkOutput("done_seen", 64'(finished), 64'd1);
    @(negedge axis_clk);
    start = 1'b0; t_ready = 1'b1;
    repeat (3) @(negedge axis_clk);
  endtask

  task automatic checkPacket(input string name, input int n0, input int addr, input int n,
                             input logic [63:0] lastKeep, input bit timing);
    logic [63:0] expKeep;
    checkOutput({name, "_ena_count"}, 64'(enaCyc.size()), 64'(n));
    checkOutput({name, "_beat_count"}, 64'(beatCyc.size()), 64'(n));
    checkOutput({name, "_done_pulses"}, 64'(doneCyc.size()), 64'd1);
    for (int i = 0; i < enaAddr.size() && i < n; i++)
      checkOutput($sformatf("%s_addr%0d", name, i), 64'(enaAddr[i]), 64'((addr + i) % DEPTH));
    for (int i = 0; i < beatCyc.size() && i < n; i++) begin
      expKeep = (i == n - 1) ? ((lastKeep == 64'd0) ? AllOnes : lastKeep) : AllOnes;
      checkOutput($sformatf("%s_data%0d", name, i), beatData[i], 64'((addr + i) % DEPTH));
      checkOutput($sformatf("%s_keep%0d", name, i), beatKeep[i], expKeep);
      checkOutput($sformatf("%s_last%0d", name, i), 64'(beatLast[i]), 64'(i == n - 1));
    end
    checkOutput({name, "_stall_stable"}, 64'(stallErr), 64'd0);
    checkOutput({name, "_outstanding"}, 64'(outErr), 64'd0);
    if (timing && doneCyc.size() > 0) begin
      if (n == 0) begin
        checkOutput({name, "_done_cyc"}, 64'(doneCyc[0] - n0), 64'd1);
      end else begin
        checkOutput({name, "_done_cyc"}, 64'(doneCyc[0] - n0), 64'(n + 3));
        if (enaCyc.size() == n) begin
          checkOutput({name, "_ena_first"}, 64'(enaCyc[0] - n0), 64'd1);
          checkOutput({name, "_ena_last"}, 64'(enaCyc[n-1] - n0), 64'(n));
        end
        if (beatCyc.size() == n) begin
          checkOutput({name, "_beat_first"}, 64'(beatCyc[0] - n0), 64'd3);
          checkOutput({name, "_beat_last"}, 64'(beatCyc[n-1] - n0), 64'(n + 2));
        end
      end
    end
  endtask

  initial begin
    int n0;
    repeat (3) @(negedge axis_clk);
    #3;
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_ena", 64'(bram_ena), 64'd0);
    checkOutput("rst_valid", 64'(t_valid), 64'd0);
    checkOutput("rst_last", 64'(t_last), 64'd0);
    checkOutput("rst_addr", 64'(bram_address), 64'd0);
    checkOutput("rst_data", t_data[63:0], 64'd0);
    checkOutput("rst_keep", t_keep, 64'd0);
    @(negedge axis_clk);
    reset = 1'b0;
    repeat (2) @(negedge axis_clk);

    $display("[TB] case 1: 4 beats, ready high");
    applyStimulus(10'd0, 11'd4, '0, 1'b0, 1'b0, n0);
    checkPacket("c1", n0, 0, 4, 64'd0, 1'b1);

    $display("[TB] case 2: 4 beats, ready toggling");
    applyStimulus(10'd0, 11'd4, '0, 1'b1, 1'b0, n0);
    checkPacket("c2", n0, 0, 4, 64'd0, 1'b0);

    $display("[TB] case 3: address wrap");
    applyStimulus(10'd1022, 11'd4, '0, 1'b0, 1'b0, n0);
    checkPacket("c3", n0, 1022, 4, 64'd0, 1'b1);

    $display("[TB] case 4: single beat and empty packet");
    applyStimulus(10'd7, 11'd1, 64'h0000_0000_0000_00FF, 1'b0, 1'b0, n0);
    checkPacket("c4a", n0, 7, 1, 64'h0000_0000_0000_00FF, 1'b1);
    applyStimulus(10'd9, 11'd0, '0, 1'b0, 1'b0, n0);
    checkPacket("c4b", n0, 9, 0, 64'd0, 1'b1);
    checkOutput("c4b_valid_idle", 64'(t_valid), 64'd0);

    $display("[TB] case 5: clamp to depth, second start ignored");
    applyStimulus(10'd5, 11'd1025, '0, 1'b0, 1'b1, n0);
    checkPacket("c5", n0, 5, 1024, 64'd0, 1'b1);

    $display("[TB] reset mid-transfer");
    @(negedge axis_clk);
    clearLogs();
    start = 1'b1; start_addr = 10'd100; beat_count = 11'd16; last_keep = '0;
    @(negedge axis_clk);
    start = 1'b0;
    @(negedge axis_clk);
    reset = 1'b1;
    @(negedge axis_clk);
    reset = 1'b0;
    #3;
    checkOutput("rm_valid", 64'(t_valid), 64'd0);
    checkOutput("rm_ena", 64'(bram_ena), 64'd0);
    checkOutput("rm_busy", 64'(busy), 64'd0);
    checkOutput("rm_done", 64'(done), 64'd0);
    repeat (4) @(negedge axis_clk);
    #3;
    checkOutput("rm_no_done", 64'(doneCyc.size()), 64'd0);
    checkOutput("rm_stays_idle", 64'(busy), 64'd0);
    applyStimulus(10'd200, 11'd3, '0, 1'b0, 1'b0, n0);
    checkPacket("rm_after", n0, 200, 3, 64'd0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
